// File: rtl/dram_arb_pkg.sv
// Shared types and widths for the two-port data RAM arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int unsigned CNTW = 8;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector with a bounded burst lock.
// req[0] / gnt[0] is the core, req[1] / gnt[1] is the DMA; last = 1 means DMA won last.
import dram_arb_pkg::*;

module rr_pick (
  input  logic [1:0]      req,
  input  owner_t          owner,
  input  logic            last,
  input  logic [CNTW-1:0] cnt,
  input  logic [CNTW-1:0] maxburst,
  output logic [1:0]      gnt
);

  logic burst_open;

  always_comb begin
    gnt        = 2'b00;
    burst_open = (cnt < maxburst);
    // An owner keeps the RAM until its burst is spent, or forever if the other side is idle
    if (owner == OWN_CORE && req[0] && (burst_open || !req[1])) begin
      gnt = 2'b01;
    end else if (owner == OWN_DMA && req[1] && (burst_open || !req[0])) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the single-port data RAM between the core (port 0) and the JPEG DMA (port 1),
// drives the RAM and steers the 1-cycle read return back to the requester that issued it.
import dram_arb_pkg::*;

module dram_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRW    = 32,
  parameter int unsigned MAXBURST = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [ADDRW-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_gnt,
  output logic             core_rvalid,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [ADDRW-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [CNTW-1:0] MAXB = CNTW'(MAXBURST);

  owner_t          owner;
  logic            last;
  logic [CNTW-1:0] cnt;
  logic            rtag_core;
  logic            rtag_dma;
  logic [1:0]      pick;

  rr_pick u_pick (
    .req      ({dma_req, core_req}),
    .owner    (owner),
    .last     (last),
    .cnt      (cnt),
    .maxburst (MAXB),
    .gnt      (pick)
  );

  // Grants are combinational; force them low while reset is held
  assign core_gnt = pick[0] & nreset;
  assign dma_gnt  = pick[1] & nreset;

  always_comb begin
    ram_en    = core_gnt | dma_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (core_gnt) begin
      ram_we    = core_we;
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
    end else if (dma_gnt) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      owner     <= OWN_NONE;
      last      <= 1'b1;
      cnt       <= '0;
      rtag_core <= 1'b0;
      rtag_dma  <= 1'b0;
    end else begin
      rtag_core <= core_gnt & ~core_we;
      rtag_dma  <= dma_gnt & ~dma_we;
      if (core_gnt) begin
        owner <= OWN_CORE;
        if (owner == OWN_CORE) begin
          if (cnt < MAXB) cnt <= cnt + CNTW'(1);
        end else begin
          cnt  <= CNTW'(1);
          last <= 1'b0;
        end
      end else if (dma_gnt) begin
        owner <= OWN_DMA;
        if (owner == OWN_DMA) begin
          if (cnt < MAXB) cnt <= cnt + CNTW'(1);
        end else begin
          cnt  <= CNTW'(1);
          last <= 1'b1;
        end
      end else begin
        owner <= OWN_NONE;
        cnt   <= '0;
      end
    end
  end

  assign core_rvalid = rtag_core;
  assign dma_rvalid  = rtag_dma;
  assign rdata       = nreset ? ram_rdata : '0;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the RISC-V core data port (port 0) and the JPEG block DMA engine (port 1).
- Performs round-robin arbitration with a bounded burst lock, drives the RAM, and routes 1-cycle-latency read data back to the owning requester.
- Sits between the core's ramaddress/writeram/writeramdata interface and the RAM macro.
- At SoC level, the core's PC hold is derived as core_req & ~core_gnt.

Parameters:
- WIDTH, 32, data width of RAM words and both requester data buses.
- ADDRW, 32, address width.
- MAXBURST, 8, consecutive grants one requester may hold while the other is requesting; legal range 1..255.

Ports:
- clock  input  1  system clock, all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- core_req  input  1  core requests a RAM access this cycle.
- core_we  input  1  1 = write, 0 = read.
- core_addr  input  ADDRW  core word address.
- core_wdata  input  WIDTH  core write data.
- core_gnt  output  1  core access accepted this cycle.
- core_rvalid  output  1  core read data valid this cycle.
- dma_req  input  1  DMA requests a RAM access.
- dma_we  input  1  1 = write, 0 = read.
- dma_addr  input  ADDRW  DMA word address.
- dma_wdata  input  WIDTH  DMA write data.
- dma_gnt  output  1  DMA access accepted this cycle.
- dma_rvalid  output  1  DMA read data valid this cycle.
- rdata  output  WIDTH  read data, broadcast to both requesters; qualify with the rvalid signals.
- ram_en  output  1  RAM access strobe.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDRW  RAM address.
- ram_wdata  output  WIDTH  RAM write data.
- ram_rdata  input  WIDTH  RAM read data, valid the cycle after ram_en with ram_we = 0.

Behaviour:
- Reset and registers:
  - Asynchronous on nreset low.
  - Owner register: NONE / CORE / DMA, resets to NONE.
  - last register: resets to DMA, so the core wins the first tie.
  - burst count cnt: 8 bits, resets to 0.
  - Read tag registers rtag_core / rtag_dma: reset to 0.
  - While nreset is low, all outputs are 0.
- Grant selection (combinational in the current cycle):
  - Owner = X, X still requesting, and cnt < MAXBURST: grant X.
  - Owner = X, X requesting, cnt == MAXBURST, other requester idle: grant X again.
  - Otherwise, if both request: grant the requester that is not `last`.
  - Otherwise, grant whichever single requester is requesting; if none, grant nothing.
  - At most one gnt is high in any cycle. A gnt is high only if its req is high.
- Access:
  - Acceptance occurs in the same cycle as req & gnt; there is no wait state.
  - ram_en = core_gnt | dma_gnt.
  - ram_we, ram_addr, ram_wdata are muxed from the granted port.
  - With no grant, ram_we, ram_addr and ram_wdata are 0.
- Register update on the clock edge:
  - Grant to X with owner == X: cnt <= min(cnt+1, MAXBURST).
  - Grant to X with owner != X: cnt <= 1, last <= X.
  - No grant: owner <= NONE, cnt <= 0; last is held.
  - owner <= the granted requester.
- Read return:
  - rtag_X <= gnt_X & ~we_X.
  - X_rvalid = rtag_X, i.e. exactly 1 cycle after acceptance.
  - rdata = ram_rdata, unregistered pass-through.
  - Back-to-back reads give one rvalid per cycle, in order.
  - Writes never produce rvalid.
- Fairness: under continuous contention, the pattern is MAXBURST grants to one requester, then MAXBURST to the other. Neither starves for longer than MAXBURST cycles.
- Requester obligation: each requester holds req/we/addr/wdata stable until gnt. The arbiter does not buffer requests.
- Reset mid-operation: a pending rvalid is dropped. After release, arbitration restarts as from power-up.
- MAXBURST = 1: strict alternation under contention.

Decomposition:
- Package dram_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CORE, OWN_DMA}.
  - Localparam CNTW = 8.
- Sub-module rr_pick: pure combinational 2-way round-robin selector.
  - Inputs: req[1:0], owner, last, cnt, MAXBURST.
  - Output: one-hot gnt[1:0].
  - Unit-testable standalone.
- Top level holds the registers, the RAM mux and the read tags.

Test Plan:
1. Reset, then core_req = 1 (read, addr 0x10), dma_req = 0, with ram_rdata = 0xDEADBEEF returned next cycle -> core_gnt = 1 the same cycle, ram_en = 1, ram_we = 0, ram_addr = 0x10; next cycle core_rvalid = 1, rdata = 0xDEADBEEF, dma_rvalid = 0.
2. Both requesters assert in the first cycle after reset -> core granted first. With MAXBURST = 8 and both held continuously: core_gnt for cycles 0-7, dma_gnt for cycles 8-15, core_gnt again at cycle 16.
3. DMA writes a burst of 20 to addresses 0x100..0x113 while the core is idle -> dma_gnt for all 20 consecutive cycles, ram_we = 1, ram_wdata = dma_wdata, and no rvalid on either port.
4. Core read at cycle N, then DMA read at cycle N+1 (alternating single requests) -> core_rvalid at N+1, dma_rvalid at N+2; each rdata matches the RAM model.
5. Assert nreset low in the cycle after a granted core read -> core_rvalid = 0 and all outputs 0 during reset. After release, a simultaneous request grants the core first.
6. MAXBURST = 1, both requesters continuous for 6 cycles -> grants are core, dma, core, dma, core, dma; never two gnt high together (assertion checked every cycle).
